// File: rtl/tag_decompressor.sv
// Codebook tag decompressor: loads an 8-entry codebook, then expands each
// 24-bit tag word (eight 3-bit indices) into eight 24-bit pixels written one
// per cycle. The next tag word is prefetched during pixel 6 so there is no gap
// between words.
module tag_decompressor #(
  parameter logic [19:0] CB_BASE   = 20'h00000,
  parameter logic [19:0] TAG_BASE  = 20'h00000,
  parameter int          TAG_WORDS = 4096,
  parameter logic [19:0] OUT_BASE  = 20'h00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] CB_Q,
  output logic [19:0] CB_A,
  output logic        CB_OE,
  input  logic [23:0] TAG_Q,
  output logic [19:0] TAG_A,
  output logic        TAG_OE,
  output logic [23:0] OUT_D,
  output logic [19:0] OUT_A,
  output logic        OUT_WE,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CB_LOAD,
    S_CB_LAST,
    S_TAG_FETCH,
    S_TAG_LOAD,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [12:0] LAST_WORD = 13'(TAG_WORDS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cb_cnt;
  logic [23:0] cb [0:7];
  logic [23:0] tag_reg;
  logic [12:0] word;
  logic [2:0]  k;
  logic [4:0]  sel_lsb;
  logic [2:0]  pix_sel;

  // State register; reset returns straight to IDLE so all strobes drop at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Index of the current pixel inside the held tag word (pixel 0 in the LSBs).
  always_comb begin
    sel_lsb = 5'(k) * 5'd3;
    pix_sel = tag_reg[sel_lsb +: 3];
  end

  // Next-state and strobe/address decode; every output is a function of registers only.
  always_comb begin
    state_nxt = state;
    CB_OE     = 1'b0;
    CB_A      = 20'h0;
    TAG_OE    = 1'b0;
    TAG_A     = 20'h0;
    OUT_WE    = 1'b0;
    OUT_A     = 20'h0;
    OUT_D     = 24'h0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CB_LOAD;
      end
      S_CB_LOAD: begin
        busy  = 1'b1;
        CB_OE = 1'b1;
        CB_A  = CB_BASE + 20'(cb_cnt);
        if (cb_cnt == 3'd7) state_nxt = S_CB_LAST;
      end
      S_CB_LAST: begin
        busy      = 1'b1;
        state_nxt = S_TAG_FETCH;
      end
      S_TAG_FETCH: begin
        busy      = 1'b1;
        TAG_OE    = 1'b1;
        TAG_A     = TAG_BASE;
        state_nxt = S_TAG_LOAD;
      end
      S_TAG_LOAD: begin
        busy      = 1'b1;
        state_nxt = S_EMIT;
      end
      S_EMIT: begin
        busy   = 1'b1;
        OUT_WE = 1'b1;
        OUT_A  = OUT_BASE + 20'({word, k});
        OUT_D  = cb[pix_sel];
        // Issue the next word's read two cycles early so it lands on the k=7 edge.
        if (k == 3'd6 && word != LAST_WORD) begin
          TAG_OE = 1'b1;
          TAG_A  = TAG_BASE + 20'(word) + 20'd1;
        end
        if (k == 3'd7 && word == LAST_WORD) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_CB_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Codebook capture, tag word register and pixel/word counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cb_cnt  <= 3'd0;
      tag_reg <= 24'h0;
      word    <= 13'd0;
      k       <= 3'd0;
      for (int i = 0; i < 8; i++) cb[i] <= 24'h0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) cb_cnt <= 3'd0;
        end
        S_CB_LOAD: begin
          cb_cnt <= cb_cnt + 3'd1;
          // Read data trails the address by one cycle.
          if (cb_cnt != 3'd0) cb[cb_cnt - 3'd1] <= CB_Q;
        end
        S_CB_LAST: begin
          cb[7] <= CB_Q;
        end
        S_TAG_LOAD: begin
          tag_reg <= TAG_Q;
          word    <= 13'd0;
          k       <= 3'd0;
        end
        S_EMIT: begin
          k <= k + 3'd1;
          if (k == 3'd7) begin
            tag_reg <= TAG_Q;
            word    <= word + 13'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_decompressor.sv
// Randomised bench for tag_decompressor: RAM models, a pixel reference model
// feeding a scoreboard queue, and a monitor that checks every pixel write.
module tb_tag_decompressor;

  localparam int TW      = 4096;
  localparam int NPIX    = 8 * TW;
  localparam int RUN_CYC = 1 + 8 + 1 + 2 + NPIX;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] CB_Q;
  logic [19:0] CB_A;
  logic        CB_OE;
  logic [23:0] TAG_Q;
  logic [19:0] TAG_A;
  logic        TAG_OE;
  logic [23:0] OUT_D;
  logic [19:0] OUT_A;
  logic        OUT_WE;
  logic        busy;
  logic        done;

  tag_decompressor #(
    .CB_BASE  (20'h00000),
    .TAG_BASE (20'h00000),
    .TAG_WORDS(TW),
    .OUT_BASE (20'h00000)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .CB_Q  (CB_Q),
    .CB_A  (CB_A),
    .CB_OE (CB_OE),
    .TAG_Q (TAG_Q),
    .TAG_A (TAG_A),
    .TAG_OE(TAG_OE),
    .OUT_D (OUT_D),
    .OUT_A (OUT_A),
    .OUT_WE(OUT_WE),
    .busy  (busy),
    .done  (done)
  );

  typedef struct packed {
    logic [19:0] a;
    logic [23:0] d;
  } wr_t;

  logic [23:0] cb_mem  [0:7];
  logic [23:0] tag_mem [0:TW-1];
  wr_t         exp_q [$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_wr_cyc = 0;
  int          last_wr_addr = -1;
  int          s_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAMs: data appears the cycle after the enable.
  always @(posedge clk) begin
    if (CB_OE)  CB_Q  <= (CB_A < 20'd8) ? cb_mem[CB_A[2:0]] : 24'hBAD0BA;
    if (TAG_OE) TAG_Q <= (TAG_A < 20'(TW)) ? tag_mem[TAG_A[11:0]] : 24'hBAD7A6;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: pixel p takes the codebook entry named by 3-bit field p%8 of word p/8.
  function automatic logic [23:0] ref_pixel(input int p);
    int w;
    int sh;
    int idx;
    w   = p / 8;
    sh  = 3 * (p % 8);
    idx = int'((tag_mem[w] >> sh) & 24'h7);
    return cb_mem[idx];
  endfunction

  task automatic push_expected();
    wr_t e;
    exp_q.delete();
    for (int p = 0; p < NPIX; p++) begin
      e.a = 20'(p);
      e.d = ref_pixel(p);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (OUT_WE) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h with nothing expected", OUT_A);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("out_addr", 64'(OUT_A), 64'(e.a));
          chk("out_data", 64'(OUT_D), 64'(e.d));
        end
        last_wr_cyc  = cyc;
        last_wr_addr = int'(OUT_A);
      end
      if (CB_OE || TAG_OE) chk("oe_exclusive", 64'(CB_OE & TAG_OE), 64'd0);
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_image(input bit noise);
    int n;
    push_expected();
    pulse_start();
    chk("done_cleared", 64'(done), 64'd0);
    chk("busy_set", 64'(busy), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk("cb_oe", 64'(CB_OE), 64'd1);
      chk("cb_addr", 64'(CB_A), 64'(i));
      @(negedge clk);
    end
    chk("cb_oe_off", 64'(CB_OE), 64'd0);
    n = 0;
    while (!done && n < RUN_CYC + 20) begin
      start = noise && (n == 100 || n == 5000 || n == 30000);
      if (n == 2000) chk("busy_mid", 64'(busy), 64'd1);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 expected done=1 after %0d cycles", n);
    end else begin
      chk("run_length", 64'(cyc - s_cyc), 64'(RUN_CYC));
      chk("last_addr", 64'(last_wr_addr), 64'(NPIX - 1));
      chk("done_after_last", 64'(cyc - last_wr_cyc), 64'd1);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      chk("busy_in_done", 64'(busy), 64'd0);
    end
    @(negedge clk);
    chk("done_hold", 64'(done), 64'd1);
    chk("we_in_done", 64'(OUT_WE), 64'd0);
  endtask

  initial begin
    int n;
    bit quiet;
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 8; i++) cb_mem[i] = 24'h111111 * 24'(i);
    for (int w = 0; w < TW; w++) tag_mem[w] = 24'($urandom);
    tag_mem[0] = 24'hFAC688;
    tag_mem[1] = 24'hFFFFFF;
    tag_mem[2] = 24'h000000;

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        64'({CB_A, CB_OE, TAG_A, TAG_OE, OUT_D, OUT_A, OUT_WE, busy, done}), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);

    // Run 1: known codebook, ordered/uniform words first, start noise while busy.
    run_image(1'b1);

    // Run 2: restart from DONE with a new codebook, then reset at word 5 pixel 3.
    for (int i = 0; i < 8; i++) cb_mem[i] = 24'($urandom);
    push_expected();
    pulse_start();
    chk("restart_done_low", 64'(done), 64'd0);
    n = 0;
    while (!(OUT_WE && OUT_A == 20'd43) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL reach_pixel43: got no write to 43 expected one within 200 cycles");
    end
    #2 rst = 1'b0;
    #1;
    chk("rst_we", 64'(OUT_WE), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_oe", 64'({CB_OE, TAG_OE}), 64'd0);
    chk("rst_addr", 64'(OUT_A), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (CB_OE || TAG_OE || OUT_WE || busy || done) quiet = 1'b0;
    end
    chk("idle_after_reset", 64'(quiet), 64'd1);

    // Run 3: fully random codebook and tags from IDLE.
    for (int i = 0; i < 8; i++) cb_mem[i] = 24'($urandom);
    for (int w = 0; w < TW; w++) tag_mem[w] = 24'($urandom);
    run_image(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
